// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory arbiter: widths, FSM encodings and port indices.
package dmem_pkg;

  localparam int unsigned AW = 10;  // word address width (1024 words)
  localparam int unsigned DW = 32;  // data width

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_e;

  localparam logic PORT_CPU  = 1'b0;  // CPU load/store path
  localparam logic PORT_LOAD = 1'b1;  // test/loader path

endpackage

// File: rtl/dmem_arbiter_if.sv
// Requester-side bus of the data-memory arbiter.
//   master : a requester pair (drives req/we/addr/wdata, sees ack/rdata/busy/owner)
//   slave  : the arbiter
interface dmem_arbiter_if #(
  parameter int unsigned AW = dmem_pkg::AW,
  parameter int unsigned DW = dmem_pkg::DW
);

  logic          req0;
  logic          we0;
  logic [AW-1:0] addr0;
  logic [DW-1:0] wdata0;
  logic          ack0;

  logic          req1;
  logic          we1;
  logic [AW-1:0] addr1;
  logic [DW-1:0] wdata1;
  logic          ack1;

  logic [DW-1:0] rdata;
  logic          busy;
  logic          owner;

  modport master (
    output req0, we0, addr0, wdata0,
    output req1, we1, addr1, wdata1,
    input  ack0, ack1, rdata, busy, owner
  );

  modport slave (
    input  req0, we0, addr0, wdata0,
    input  req1, we1, addr1, wdata1,
    output ack0, ack1, rdata, busy, owner
  );

endinterface

// File: rtl/rr_pick2.sv
// Two-way round-robin pick (combinational).
//   req0, req1   : requests
//   last_owner   : index of the port served most recently
//   grant_valid  : at least one request present
//   grant_idx    : chosen port; on a tie the port that was not served last wins
module rr_pick2 (
  input  logic req0,
  input  logic req1,
  input  logic last_owner,
  output logic grant_valid,
  output logic grant_idx
);

  always_comb begin
    grant_valid = req0 | req1;
    grant_idx   = (req0 && req1) ? ~last_owner : req1;
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter/sequencer in front of the 1024x32 data memory
// (asynchronous read, synchronous write). One access every three cycles:
// IDLE (grant) -> ACCESS (memory cycle) -> DONE (ack pulse).
//   clk, reset : clock, asynchronous active-high reset
//   bus        : requester ports 0/1, acks, registered rdata, busy, owner
//   mem_we/mem_addr/mem_din : memory controls, only non-zero during ACCESS
//   mem_dout   : memory combinational read data
module dmem_arbiter #(
  parameter int unsigned AW = dmem_pkg::AW,
  parameter int unsigned DW = dmem_pkg::DW
) (
  input  logic          clk,
  input  logic          reset,
  dmem_arbiter_if.slave bus,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_din,
  input  logic [DW-1:0] mem_dout
);

  import dmem_pkg::*;

  state_e        state_q, state_d;
  logic          owner_q;
  logic          last_owner_q;
  logic [DW-1:0] rdata_q;
  logic          ack0_q, ack1_q, ack0_d, ack1_d;
  logic          busy_q;
  logic          take_grant;
  logic          grant_valid, grant_idx;

  logic          sel_we;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;

  rr_pick2 u_pick (
    .req0        (bus.req0),
    .req1        (bus.req1),
    .last_owner  (last_owner_q),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  // State register plus registered outputs; ack/busy are computed one cycle
  // ahead so they line up with DONE / non-IDLE states.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      owner_q      <= PORT_CPU;
      last_owner_q <= PORT_LOAD;  // port 0 wins the first tie
      rdata_q      <= '0;
      ack0_q       <= 1'b0;
      ack1_q       <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q <= state_d;
      ack0_q  <= ack0_d;
      ack1_q  <= ack1_d;
      busy_q  <= (state_d != IDLE);
      if (take_grant) begin
        owner_q <= grant_idx;
      end
      if (state_q == ACCESS) begin
        rdata_q      <= mem_dout;  // pre-write value on writes
        last_owner_q <= owner_q;
      end
    end
  end

  // Next-state and ack decode.
  always_comb begin
    state_d    = state_q;
    take_grant = 1'b0;
    ack0_d     = 1'b0;
    ack1_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (grant_valid) begin
          take_grant = 1'b1;
          state_d    = ACCESS;
        end
      end
      ACCESS: begin
        state_d = DONE;
        ack0_d  = (owner_q == PORT_CPU);
        ack1_d  = (owner_q == PORT_LOAD);
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Owner mux onto the memory, gated so the memory only sees an access in ACCESS.
  // Reset forces state_q to IDLE asynchronously, so mem_we drops at once.
  always_comb begin
    sel_we    = bus.we0;
    sel_addr  = bus.addr0;
    sel_wdata = bus.wdata0;
    if (owner_q == PORT_LOAD) begin
      sel_we    = bus.we1;
      sel_addr  = bus.addr1;
      sel_wdata = bus.wdata1;
    end
    mem_we   = 1'b0;
    mem_addr = '0;
    mem_din  = '0;
    if (state_q == ACCESS) begin
      mem_we   = sel_we;
      mem_addr = sel_addr;
      mem_din  = sel_wdata;
    end
  end

  assign bus.ack0  = ack0_q;
  assign bus.ack1  = ack1_q;
  assign bus.rdata = rdata_q;
  assign bus.busy  = busy_q;
  assign bus.owner = owner_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural 1024x32 memory.
module tb_dmem_arbiter;

  import dmem_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  dmem_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_din;
  logic [DW-1:0] mem_dout;
  logic [DW-1:0] mem [0:(1<<AW)-1];

  dmem_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus.slave),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_din  (mem_din),
    .mem_dout (mem_dout)
  );

  // Memory model: combinational read, write on posedge.
  assign mem_dout = mem[mem_addr];
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_din;
  end

  // Requester must hold its request stable through ACCESS.
  ap_hold0: assert property (@(posedge clk) disable iff (reset)
    (dut.state_q == ACCESS && dut.owner_q == 1'b0) |->
      (bus.req0 && $stable(bus.req0) && $stable(bus.we0) && $stable(bus.addr0) && $stable(bus.wdata0)));
  ap_hold1: assert property (@(posedge clk) disable iff (reset)
    (dut.state_q == ACCESS && dut.owner_q == 1'b1) |->
      (bus.req1 && $stable(bus.req1) && $stable(bus.we1) && $stable(bus.addr1) && $stable(bus.wdata1)));
  ap_ack_excl: assert property (@(posedge clk) !(bus.ack0 && bus.ack1));

  int n_cmp = 0;
  int n_err = 0;
  time t_acc, t_ack;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One access through a single port; checks the ACCESS and DONE cycles.
  task automatic xfer(input bit port, input bit we, input logic [AW-1:0] addr,
                      input logic [DW-1:0] wd, input logic [DW-1:0] exp_rd,
                      input bit drop, input string tag);
    if (port) begin
      bus.we1 = we; bus.addr1 = addr; bus.wdata1 = wd; bus.req1 = 1'b1;
    end else begin
      bus.we0 = we; bus.addr0 = addr; bus.wdata0 = wd; bus.req0 = 1'b1;
    end
    tick();  // ACCESS
    t_acc = $time;
    chk({tag, "_acc_we"},   32'(mem_we),   32'(we));
    chk({tag, "_acc_addr"}, 32'(mem_addr), 32'(addr));
    if (we) chk({tag, "_acc_din"}, mem_din, wd);
    chk({tag, "_acc_busy"},  32'(bus.busy),  32'd1);
    chk({tag, "_acc_owner"}, 32'(bus.owner), 32'(port));
    chk({tag, "_acc_ack"},   32'({bus.ack1, bus.ack0}), 32'd0);
    tick();  // DONE
    t_ack = $time;
    chk({tag, "_done_we"}, 32'(mem_we), 32'd0);
    chk({tag, "_done_ack"}, 32'({bus.ack1, bus.ack0}), port ? 32'd2 : 32'd1);
    if (!we) chk({tag, "_rdata"}, bus.rdata, exp_rd);
    if (drop) begin
      if (port) bus.req1 = 1'b0; else bus.req0 = 1'b0;
    end
    tick();  // back to IDLE
    chk({tag, "_idle_ack"}, 32'({bus.ack1, bus.ack0}), 32'd0);
  endtask

  initial begin
    logic [DW-1:0] wv;
    int order [4];
    int nacks;
    int k0, k1;
    time t_first_acc, t_first_ack;

    for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
    reset = 1'b1;
    bus.req0 = 1'b0; bus.we0 = 1'b0; bus.addr0 = '0; bus.wdata0 = '0;
    bus.req1 = 1'b0; bus.we1 = 1'b0; bus.addr1 = '0; bus.wdata1 = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Reset values and quiet bus
    chk("rst_rdata", bus.rdata, 32'h0);
    chk("rst_owner", 32'(bus.owner), 32'd0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("quiet_busy", 32'(bus.busy), 32'd0);
      chk("quiet_we",   32'(mem_we),   32'd0);
      chk("quiet_ack",  32'({bus.ack1, bus.ack0}), 32'd0);
      chk("quiet_addr", 32'(mem_addr), 32'd0);
    end
    chk("quiet_rdata", bus.rdata, 32'h0);

    // Port 1 write then port 0 read-back
    xfer(1'b1, 1'b1, 10'd1, 32'hDEADBEEF, 32'h0, 1'b1, "p1_wr1");
    chk("mem1", mem[1], 32'hDEADBEEF);
    xfer(1'b0, 1'b0, 10'd1, 32'h0, 32'hDEADBEEF, 1'b1, "p0_rd1");
    chk("rd_latency", 32'(t_ack - t_acc), 32'd10);

    // Read of an address never written
    xfer(1'b0, 1'b0, 10'd5, 32'h0, 32'h0, 1'b1, "p0_rd5");
    chk("mem5", mem[5], 32'h0);

    // Fairness: both ports request continuously, two writes each
    reset = 1'b1;
    tick();
    reset = 1'b0;
    k0 = 0; k1 = 0; nacks = 0;
    bus.we0 = 1'b1; bus.addr0 = 10'd20; bus.wdata0 = 32'hA0; bus.req0 = 1'b1;
    bus.we1 = 1'b1; bus.addr1 = 10'd21; bus.wdata1 = 32'hB0; bus.req1 = 1'b1;
    for (int cyc = 0; cyc < 60 && nacks < 4; cyc++) begin
      tick();
      if (bus.ack0) begin
        order[nacks] = 0; nacks++; k0++;
        if (k0 == 2) bus.req0 = 1'b0; else bus.wdata0 = 32'hA0 + 32'(k0);
      end else if (bus.ack1) begin
        order[nacks] = 1; nacks++; k1++;
        if (k1 == 2) bus.req1 = 1'b0; else bus.wdata1 = 32'hB0 + 32'(k1);
      end
    end
    chk("rr_nacks", 32'(nacks), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < nacks) chk("rr_order", 32'(order[i]), 32'(i % 2));
    end
    tick();
    chk("rr_mem20", mem[20], 32'hA1);
    chk("rr_mem21", mem[21], 32'hB1);

    // Reset asserted in the middle of a port 1 write
    bus.we1 = 1'b1; bus.addr1 = 10'd7; bus.wdata1 = 32'h12345678; bus.req1 = 1'b1;
    tick();  // ACCESS
    chk("rstmid_we_pre", 32'(mem_we), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("rstmid_we",    32'(mem_we),    32'd0);
    chk("rstmid_busy",  32'(bus.busy),  32'd0);
    chk("rstmid_owner", 32'(bus.owner), 32'd0);
    bus.req1 = 1'b0; bus.we1 = 1'b0;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rstmid_ack1", 32'(bus.ack1), 32'd0);
      chk("rstmid_idle", 32'(bus.busy), 32'd0);
    end
    chk("rstmid_mem7", mem[7], 32'h0);

    // Back-to-back port 0 writes with req0 held through DONE
    xfer(1'b0, 1'b1, 10'd30, 32'hC0, 32'h0, 1'b0, "b2b_a");
    t_first_acc = t_acc;
    t_first_ack = t_ack;
    xfer(1'b0, 1'b1, 10'd31, 32'hC1, 32'h0, 1'b1, "b2b_b");
    chk("b2b_acc_gap", 32'(t_acc - t_first_acc), 32'd30);
    chk("b2b_ack_gap", 32'(t_ack - t_first_ack), 32'd30);
    chk("b2b_mem30", mem[30], 32'hC0);
    chk("b2b_mem31", mem[31], 32'hC1);
    wv = mem[1];
    chk("mem1_kept", wv, 32'hDEADBEEF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
